// File: rtl/icb_ext_sram_responder.sv
// -----------------------------------------------------------------------------
// icb_ext_sram_responder
//
// Slave end of the extended three-channel ICB (cmd / write-data / rsp). Serves
// single-beat reads and byte-masked writes out of an internal synchronous word
// SRAM. Up to OUTSTANDING responses may be in flight, so a streaming master can
// issue one command per cycle while responses return strictly in order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   icb_cmd_valid     command valid
//   icb_cmd_ready     command accepted when valid & ready
//   icb_cmd_addr      byte address (REG_WIDTH)
//   icb_cmd_read      1 = read, 0 = write
//   icb_cmd_len       beats-1; only 0 is legal, anything else is an error
//   icb_w_valid       write data valid
//   icb_w_ready       write data accepted
//   icb_w_data        write data (BUS_WIDTH)
//   icb_w_mask        byte enables, 1 = write that byte
//   icb_rsp_valid     response valid
//   icb_rsp_ready     master accepts response
//   icb_rsp_rdata     read data (0 for writes and errors)
//   icb_rsp_err       1 = error response
//
// Pipeline: accept (cycle T) -> S1 access register (T+1) -> response FIFO.
// The SRAM is read and written at the accept edge; S1 only carries the
// result for one cycle before it lands in the FIFO. Because S1 is included in
// the occupancy count used for admission, the FIFO always has room for it and
// S1 never needs to stall.
// -----------------------------------------------------------------------------
module icb_ext_sram_responder #(
  parameter int                   BUS_WIDTH   = 32,
  parameter int                   REG_WIDTH   = 32,
  parameter int                   DEPTH       = 4096,
  parameter logic [REG_WIDTH-1:0] BASE_ADDR   = {REG_WIDTH{1'b0}},
  parameter int                   OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic [REG_WIDTH-1:0]   icb_cmd_addr,
  input  logic                   icb_cmd_read,
  input  logic [2:0]             icb_cmd_len,
  input  logic                   icb_w_valid,
  output logic                   icb_w_ready,
  input  logic [BUS_WIDTH-1:0]   icb_w_data,
  input  logic [BUS_WIDTH/8-1:0] icb_w_mask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [BUS_WIDTH-1:0]   icb_rsp_rdata,
  output logic                   icb_rsp_err
);

  localparam int NBYTES = BUS_WIDTH / 8;
  localparam int OFFW   = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(OUTSTANDING + 1);
  localparam int PW     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [REG_WIDTH:0] DEPTH_LIM = (REG_WIDTH + 1)'(DEPTH);
  localparam logic [CW:0]        OCC_LIM   = (CW + 1)'(OUTSTANDING);
  localparam logic [PW-1:0]      PTR_LAST  = PW'(OUTSTANDING - 1);

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PTR_LAST) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [BUS_WIDTH-1:0] mem_q;          // synchronous read port output

  logic                 s1_valid;
  logic                 s1_pass;        // read without error: forward mem_q
  logic                 s1_err;

  logic [BUS_WIDTH-1:0] fifo_data [OUTSTANDING];
  logic                 fifo_err  [OUTSTANDING];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_count;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [CW:0]           occ;
  logic                  has_room;
  logic                  accept;
  logic [REG_WIDTH-1:0]  off;
  logic [REG_WIDTH-1:0]  idx_full;
  logic [AW-1:0]         mem_idx;
  logic                  below_base;
  logic                  above_top;
  logic                  cmd_err;
  logic                  wr_ok;
  logic                  push;
  logic                  pop;

  // Admission, handshakes and address decode for the command in flight.
  always_comb begin
    occ        = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
    has_room   = (occ < OCC_LIM);
    // Only registered occupancy feeds admission: no path from icb_rsp_ready.
    icb_cmd_ready = has_room & (icb_cmd_read | icb_w_valid);
    icb_w_ready   = icb_cmd_valid & ~icb_cmd_read & has_room;
    accept        = icb_cmd_valid & icb_cmd_ready;

    off        = icb_cmd_addr - BASE_ADDR;
    idx_full   = off >> OFFW;
    mem_idx    = idx_full[AW-1:0];
    below_base = (icb_cmd_addr < BASE_ADDR);
    above_top  = ({1'b0, idx_full} >= DEPTH_LIM);
    cmd_err    = below_base | above_top | (icb_cmd_len != 3'd0);
    wr_ok      = accept & ~icb_cmd_read & ~cmd_err;

    push = s1_valid;
    pop  = icb_rsp_valid & icb_rsp_ready;
  end

  // SRAM: byte-masked write and synchronous read at the accept edge (no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_ok) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (icb_w_mask[b]) begin
            mem[mem_idx][8*b +: 8] <= icb_w_data[8*b +: 8];
          end
        end
      end
      mem_q <= mem[mem_idx];
    end
  end

  // S1 access register: carries response kind for one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pass  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_pass  <= icb_cmd_read & ~cmd_err;
      s1_err   <= cmd_err;
    end else begin
      s1_valid <= 1'b0;
      s1_pass  <= 1'b0;
      s1_err   <= 1'b0;
    end
  end

  // Response FIFO: push from S1, pop on rsp handshake, in-order return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= {PW{1'b0}};
      rd_ptr     <= {PW{1'b0}};
      fifo_count <= {CW{1'b0}};
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_data[i] <= {BUS_WIDTH{1'b0}};
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= s1_pass ? mem_q : {BUS_WIDTH{1'b0}};
        fifo_err[wr_ptr]  <= s1_err;
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response outputs straight from FIFO registers; zeroed while empty.
  always_comb begin
    icb_rsp_valid = (fifo_count != {CW{1'b0}});
    if (icb_rsp_valid) begin
      icb_rsp_rdata = fifo_data[rd_ptr];
      icb_rsp_err   = fifo_err[rd_ptr];
    end else begin
      icb_rsp_rdata = {BUS_WIDTH{1'b0}};
      icb_rsp_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_icb_ext_sram_responder.sv
// -----------------------------------------------------------------------------
// Bench for icb_ext_sram_responder: directed scenarios plus a randomized phase,
// every response compared against a word-array model of the scratchpad and a
// queue of expected responses in command order.
// -----------------------------------------------------------------------------
module tb_icb_ext_sram_responder;

  localparam int          BW    = 32;
  localparam int          RW    = 32;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          OUTS  = 4;

  logic          clk;
  logic          rst_n;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [RW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [2:0]    icb_cmd_len;
  logic          icb_w_valid;
  logic          icb_w_ready;
  logic [BW-1:0] icb_w_data;
  logic [3:0]    icb_w_mask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [BW-1:0] icb_rsp_rdata;
  logic          icb_rsp_err;

  icb_ext_sram_responder #(
    .BUS_WIDTH  (BW),
    .REG_WIDTH  (RW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .OUTSTANDING(OUTS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_read (icb_cmd_read),
    .icb_cmd_len  (icb_cmd_len),
    .icb_w_valid  (icb_w_valid),
    .icb_w_ready  (icb_w_ready),
    .icb_w_data   (icb_w_data),
    .icb_w_mask   (icb_w_mask),
    .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err  (icb_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_model [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stalls = 0;
  bit          lat_chk = 1'b0;
  bit          rand_ready = 1'b0;
  bit          rsp_ready_set = 1'b1;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of one accepted command: address rules, memory effect, response.
  function automatic void model_accept(input logic [31:0] addr, input bit rd,
                                       input logic [2:0] len, input logic [31:0] wd,
                                       input logic [3:0] mask);
    exp_t        e;
    bit          err;
    longint      idx;
    idx = (addr >= BASE) ? longint'((addr - BASE) / 4) : -1;
    err = (addr < BASE) || (idx >= DEPTH) || (len != 3'd0);
    e.err   = err;
    e.rdata = 32'h0;
    e.acc   = cyc;
    if (!err) begin
      if (rd) begin
        e.rdata = mem_model[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) mem_model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the command is taken.
  task automatic issue(input logic [31:0] addr, input bit rd, input logic [2:0] len,
                       input logic [31:0] wd, input logic [3:0] mask);
    bit done;
    done = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = addr;
    icb_cmd_read  = rd;
    icb_cmd_len   = len;
    icb_w_valid   = !rd;
    icb_w_data    = wd;
    icb_w_mask    = mask;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (icb_cmd_ready && (rd || icb_w_ready)) begin
        model_accept(addr, rd, len, wd, mask);
        stalls += i;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("issue_accept", done, 1'b1);
    icb_cmd_valid = 1'b0;
    icb_w_valid   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Response ready driver, updated shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #2;
      icb_rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : rsp_ready_set;
    end
  end

  // Response monitor: every visible response must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && icb_rsp_valid) begin
        if (q.size() == 0) begin
          check("spurious_rsp", icb_rsp_valid, 1'b0);
        end else begin
          check("rsp_rdata", icb_rsp_rdata, q[0].rdata);
          check("rsp_err", icb_rsp_err, q[0].err);
          if (icb_rsp_ready) begin
            if (lat_chk) check("rsp_latency", cyc - q[0].acc, 2);
            last_rdata = icb_rsp_rdata;
            last_err   = icb_rsp_err;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int acc_cnt;
    bit back;
    logic [31:0] a;
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = BASE;
    icb_cmd_read  = 1'b1;
    icb_cmd_len   = 3'd0;
    icb_w_valid   = 1'b0;
    icb_w_data    = 32'h0;
    icb_w_mask    = 4'h0;
    icb_rsp_ready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", icb_rsp_valid, 1'b0);
    check("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
    check("rst_rsp_err", icb_rsp_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", icb_cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Prefill a 32-word window so every read in range has known contents
    for (int i = 0; i < 32; i++) issue(BASE + 32'(i * 4), 1'b0, 3'd0, $urandom, 4'hF);
    drain();

    // Write then read, latency 2
    lat_chk = 1'b1;
    issue(BASE + 32'h10, 1'b0, 3'd0, 32'h1122_3344, 4'hF);
    issue(BASE + 32'h10, 1'b1, 3'd0, 32'h0, 4'h0);
    drain();
    check("t1_rdata", last_rdata, 32'h1122_3344);
    check("t1_err", last_err, 1'b0);

    // Partial mask
    issue(BASE + 32'h10, 1'b0, 3'd0, 32'hAABB_CCDD, 4'b0101);
    issue(BASE + 32'h12, 1'b1, 3'd0, 32'h0, 4'h0);
    drain();
    check("t2_rdata", last_rdata, 32'h11BB_33DD);

    // Eight back-to-back reads, no stalls, each with latency 2
    stalls = 0;
    for (int i = 0; i < 8; i++) issue(BASE + 32'(i * 4), 1'b1, 3'd0, 32'h0, 4'h0);
    check("t3_stalls", stalls, 0);
    drain();
    lat_chk = 1'b0;

    // Backpressure: exactly OUTSTANDING accepted
    rsp_ready_set = 1'b0;
    idle(2);
    acc_cnt = 0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_len   = 3'd0;
    icb_cmd_addr  = BASE + 32'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (icb_cmd_ready) begin
        model_accept(icb_cmd_addr, 1'b1, 3'd0, 32'h0, 4'h0);
        acc_cnt++;
      end
      @(posedge clk); #1;
      icb_cmd_addr = BASE + 32'h20 + 32'(acc_cnt * 4);
    end
    check("t4_accepted", acc_cnt, OUTS);
    @(negedge clk);
    check("t4_cmd_ready_low", icb_cmd_ready, 1'b0);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    rsp_ready_set = 1'b1;
    back = 1'b0;
    for (int i = 0; i < 20 && !back; i++) begin
      @(negedge clk);
      back = icb_cmd_ready;
    end
    check("t4_cmd_ready_back", back, 1'b1);
    @(posedge clk); #1;
    drain();

    // Error cases
    issue(BASE + 32'(DEPTH * 4), 1'b1, 3'd0, 32'h0, 4'h0);
    drain();
    check("t5_range_err", last_err, 1'b1);
    check("t5_range_rdata", last_rdata, 32'h0);
    issue(BASE - 32'h4, 1'b1, 3'd0, 32'h0, 4'h0);
    drain();
    check("t5_below_err", last_err, 1'b1);
    issue(BASE + 32'h10, 1'b1, 3'd1, 32'h0, 4'h0);
    drain();
    check("t5_len_err", last_err, 1'b1);
    issue(BASE + 32'h10, 1'b0, 3'd1, 32'hDEAD_BEEF, 4'hF);
    issue(BASE + 32'h10, 1'b1, 3'd0, 32'h0, 4'h0);
    drain();
    check("t5_err_write_nochange", last_rdata, 32'h11BB_33DD);

    // Randomized traffic with random response backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      if (k < 5)       issue(a, 1'b1, 3'd0, 32'h0, 4'h0);
      else if (k < 9)  issue(a, 1'b0, 3'd0, $urandom, 4'($urandom_range(0, 15)));
      else if (k == 9 && $urandom_range(0, 1) == 1)
                       issue(a, 1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), $urandom, 4'hF);
      else             issue(BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64)), 1'b1, 3'd0, 32'h0, 4'h0);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    rsp_ready_set = 1'b1;
    idle(1);
    drain();

    // Reset with responses pending
    rsp_ready_set = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) issue(BASE + 32'(i * 4), 1'b1, 3'd0, 32'h0, 4'h0);
    idle(3);
    rst_n = 1'b0;
    q.delete();
    icb_cmd_read = 1'b1;
    @(negedge clk);
    check("t6_rsp_valid", icb_rsp_valid, 1'b0);
    check("t6_cmd_ready", icb_cmd_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready_set = 1'b1;
    idle(10);
    @(negedge clk);
    check("t6_no_stale", icb_rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
